// File: rtl/derm_pkg.sv
// Shared types and constants for the ping-pong de-rate-matching input buffer.
// Latency: none (types, constants and a constant helper only).
// Backpressure: not applicable.
package derm_pkg;

    // Ownership state of one bank.
    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_t;

    // Bit positions inside o_err.
    localparam int ERR_W          = 4;
    localparam int ERR_WR_DROP    = 0;
    localparam int ERR_COMMIT     = 1;
    localparam int ERR_RD_UNAVAIL = 2;
    localparam int ERR_RD_RANGE   = 3;

    // LSB of lane 'lane' inside a packed lane bus of 'width'-bit lanes.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/DualPort_SRAM.sv
// Simple dual-port SRAM: one write port, one read port, common clock.
// Latency: 1 cycle, q is registered on the rising edge when re is high.
// Backpressure: none; every enabled access is performed.
module DualPort_SRAM #(
    parameter int DW = 10,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] q
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    // Storage write; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Registered read, holds last value when not reading.
    always_ff @(posedge clk) begin
        if (re) begin
            q <= r_mem[raddr];
        end
    end

endmodule

// File: rtl/derm_input_pingpong_buffer_mem.sv
// Lane memory array: one DualPort_SRAM per user lane, bank bit is the address MSB.
// Latency: 1 cycle from i_re to o_rdata.
// Backpressure: none; the controller guarantees writer and reader use different banks.
module derm_input_pingpong_buffer_mem
    import derm_pkg::*;
#(
    parameter int DATA_W    = 10,
    parameter int ADDR_W    = 11,
    parameter int NUM_USERS = 16
) (
    input  logic                          i_clk,
    input  logic [NUM_USERS-1:0]          i_we,
    input  logic [ADDR_W:0]               i_waddr,
    input  logic [NUM_USERS*DATA_W-1:0]   i_wdata,
    input  logic                          i_re,
    input  logic [ADDR_W:0]               i_raddr,
    output logic [NUM_USERS*DATA_W-1:0]   o_rdata
);

    for (genvar k = 0; k < NUM_USERS; k++) begin : g_lane
        DualPort_SRAM #(
            .DW (DATA_W),
            .AW (ADDR_W + 1)
        ) u_sram (
            .clk   (i_clk),
            .we    (i_we[k]),
            .waddr (i_waddr),
            .wdata (i_wdata[lane_lsb(k, DATA_W) +: DATA_W]),
            .re    (i_re),
            .raddr (i_raddr),
            .q     (o_rdata[lane_lsb(k, DATA_W) +: DATA_W])
        );
    end

endmodule

// File: rtl/derm_input_pingpong_buffer.sv
// Double-buffered (ping/pong) per-lane input buffer between demapper and de-rate-matching core.
// Latency: read data 1 cycle after an accepted i_rd_req; commit/release visible the next cycle.
// Backpressure: o_wr_ready low when the write bank is FULL; o_rd_avail low when the read bank is EMPTY.
module derm_input_pingpong_buffer
    import derm_pkg::*;
#(
    parameter int DATA_W    = 10,
    parameter int ADDR_W    = 11,
    parameter int NUM_USERS = 16
) (
    input  logic                          i_core_clk,
    input  logic                          i_rx_rst,
    input  logic [NUM_USERS-1:0]          i_wr_en,
    input  logic [ADDR_W-1:0]             i_wr_addr,
    input  logic [NUM_USERS*DATA_W-1:0]   i_wr_data,
    input  logic                          i_wr_commit,
    input  logic [ADDR_W:0]               i_wr_len,
    output logic                          o_wr_ready,
    input  logic                          i_rd_req,
    input  logic [ADDR_W-1:0]             i_rd_addr,
    output logic                          o_rd_valid,
    output logic [NUM_USERS*DATA_W-1:0]   o_rd_data,
    output logic                          o_rd_avail,
    output logic [ADDR_W:0]               o_rd_len,
    input  logic                          i_rd_release,
    output logic [1:0]                    o_banks_full,
    output logic [ERR_W-1:0]              o_err,
    input  logic                          i_err_clr
);

    localparam logic [ADDR_W:0] LP_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    // Registered control state
    bank_state_t       r_bank_st [2];
    logic [ADDR_W:0]   r_len     [2];
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [ERR_W-1:0]  r_err;
    logic              r_rd_vld;

    // Next-state and decode wires
    bank_state_t       w_bank_st_nxt [2];
    logic [ADDR_W:0]   w_len_nxt     [2];
    logic              w_wr_bank_nxt;
    logic              w_rd_bank_nxt;
    logic [ERR_W-1:0]  w_err_set;
    logic [ERR_W-1:0]  w_err_nxt;
    logic              w_wr_ready;
    logic              w_rd_avail;
    logic              w_len_ok;
    logic              w_commit_acc;
    logic              w_rd_acc;
    logic              w_rel_acc;
    logic [NUM_USERS-1:0] w_wr_we;
    logic [1:0]        w_full_cnt;

    // Handshake acceptance decode
    always_comb begin
        w_wr_ready   = (r_bank_st[r_wr_bank] == BANK_EMPTY);
        w_rd_avail   = (r_bank_st[r_rd_bank] == BANK_FULL);
        w_len_ok     = (i_wr_len != '0) && (i_wr_len <= LP_DEPTH);
        w_commit_acc = i_wr_commit && w_wr_ready && w_len_ok;
        w_rd_acc     = i_rd_req && w_rd_avail;
        w_rel_acc    = i_rd_release && w_rd_avail;
        w_wr_we      = i_wr_en & {NUM_USERS{w_wr_ready}};
        w_full_cnt   = {1'b0, (r_bank_st[0] == BANK_FULL)} + {1'b0, (r_bank_st[1] == BANK_FULL)};
    end

    // Bank FSM next state: commit fills the write bank, release drains the read bank.
    // Both can fire together; they always target different banks.
    always_comb begin
        w_bank_st_nxt = r_bank_st;
        w_len_nxt     = r_len;
        w_wr_bank_nxt = r_wr_bank;
        w_rd_bank_nxt = r_rd_bank;
        if (w_commit_acc) begin
            w_bank_st_nxt[r_wr_bank] = BANK_FULL;
            w_len_nxt[r_wr_bank]     = i_wr_len;
            w_wr_bank_nxt            = ~r_wr_bank;
        end
        if (w_rel_acc) begin
            w_bank_st_nxt[r_rd_bank] = BANK_EMPTY;
            w_rd_bank_nxt            = ~r_rd_bank;
        end
    end

    // Sticky error flags; new events win over a same-cycle clear.
    always_comb begin
        w_err_set = '0;
        w_err_set[ERR_WR_DROP]    = (|i_wr_en) && !w_wr_ready;
        w_err_set[ERR_COMMIT]     = i_wr_commit && !(w_wr_ready && w_len_ok);
        w_err_set[ERR_RD_UNAVAIL] = (i_rd_req || i_rd_release) && !w_rd_avail;
        w_err_set[ERR_RD_RANGE]   = w_rd_acc && ({1'b0, i_rd_addr} >= r_len[r_rd_bank]);
        w_err_nxt = (i_err_clr ? '0 : r_err) | w_err_set;
    end

    // Control state register with synchronous reset; memory is left untouched.
    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            r_bank_st[0] <= BANK_EMPTY;
            r_bank_st[1] <= BANK_EMPTY;
            r_len[0]     <= '0;
            r_len[1]     <= '0;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_err        <= '0;
            r_rd_vld     <= 1'b0;
        end else begin
            r_bank_st <= w_bank_st_nxt;
            r_len     <= w_len_nxt;
            r_wr_bank <= w_wr_bank_nxt;
            r_rd_bank <= w_rd_bank_nxt;
            r_err     <= w_err_nxt;
            r_rd_vld  <= w_rd_acc;
        end
    end

    derm_input_pingpong_buffer_mem #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .NUM_USERS (NUM_USERS)
    ) u_mem (
        .i_clk   (i_core_clk),
        .i_we    (w_wr_we),
        .i_waddr ({r_wr_bank, i_wr_addr}),
        .i_wdata (i_wr_data),
        .i_re    (w_rd_acc),
        .i_raddr ({r_rd_bank, i_rd_addr}),
        .o_rdata (o_rd_data)
    );

    assign o_wr_ready   = w_wr_ready;
    assign o_rd_avail   = w_rd_avail;
    assign o_rd_len     = r_len[r_rd_bank];
    assign o_banks_full = w_full_cnt;
    assign o_err        = r_err;
    assign o_rd_valid   = r_rd_vld;

endmodule
